// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the memory stage: bus/data widths, the
// memory FSM state type and the M/W pipeline payloads.
package cpu_pkg;

  localparam int unsigned DATA_W             = 32;
  localparam int unsigned REG_AW             = 5;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Fields of the M instruction that travel on to the W stage
  typedef struct packed {
    logic              reg_write;
    logic              result_src;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] alu_result;
  } m_fields_t;

  typedef struct packed {
    m_fields_t         m;
    logic [DATA_W-1:0] read_data;
  } w_fields_t;

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface memory_cycle_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mw_pipe_reg.sv
// M-to-W pipeline register: bubble clears the register-write enable and holds
// the rest; load captures a full payload.
module mw_pipe_reg
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      bubble,
  input  w_fields_t d,
  output w_fields_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q.m.reg_write <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: runs loads/stores over the req/ack bus, stalls the
// upstream stage while busy and registers the result into W.
// Optional bus-timeout watchdog with sticky MemErr: define MEM_TIMEOUT_EN.
module memory_cycle
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALU_ResultM,
  output logic              StallM,
  memory_cycle_if.master    bus,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [REG_AW-1:0] RD_W,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ResultW,
  output logic              MemErr
);

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_BUSY = 1'(BUSY);

  logic [0:0]        state, state_nx;
  logic              req_nx, we_nx;
  logic [DATA_W-1:0] addr_nx, wdata_nx;
  logic              memop;
  m_fields_t         m_in, lat, lat_nx;
  logic              w_load, w_bubble;
  w_fields_t         w_d, w_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             err, err_nx;
  logic             timeout;

  // Last permitted BUSY cycle without an ack; an ack in this cycle still wins
  assign timeout = (state == ST_BUSY) && !bus.mem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign MemErr  = err;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign MemErr = 1'b0;
`endif

  assign memop = MemWriteM | ResultSrcM;
  assign m_in  = '{reg_write:  RegWriteM,
                   result_src: ResultSrcM,
                   rd:         RD_M,
                   pc_plus4:   PCPlus4M,
                   alu_result: ALU_ResultM};

  // Next-state, bus and W-stage control
  always_comb begin
    state_nx = state;
    req_nx   = bus.mem_req;
    we_nx    = bus.mem_we;
    addr_nx  = bus.mem_addr;
    wdata_nx = bus.mem_wdata;
    lat_nx   = lat;
    StallM   = 1'b0;
    w_load   = 1'b0;
    w_bubble = 1'b0;
    w_d      = '{m: m_in, read_data: '0};
`ifdef MEM_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
    err_nx      = err;
`endif
    case (state)
      ST_IDLE: begin
        if (memop) begin
          StallM   = 1'b1;
          state_nx = ST_BUSY;
          req_nx   = 1'b1;
          we_nx    = MemWriteM;
          addr_nx  = ALU_ResultM;
          wdata_nx = WriteDataM;
          lat_nx   = m_in;
          w_bubble = 1'b1;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_nx = '0;
`endif
        end else begin
          w_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack) begin
          state_nx = ST_IDLE;
          req_nx   = 1'b0;
          w_load   = 1'b1;
          w_d      = '{m: lat, read_data: lat.result_src ? bus.mem_rdata : '0};
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout) begin
          state_nx = ST_IDLE;
          req_nx   = 1'b0;
          w_bubble = 1'b1;
          err_nx   = 1'b1;
        end
`endif
        else begin
          StallM   = 1'b1;
          w_bubble = 1'b1;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_nx = wait_cnt + CNT_W'(1);
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      lat           <= '0;
    end else begin
      state         <= state_nx;
      bus.mem_req   <= req_nx;
      bus.mem_we    <= we_nx;
      bus.mem_addr  <= addr_nx;
      bus.mem_wdata <= wdata_nx;
      lat           <= lat_nx;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nx;
      err      <= err_nx;
    end
  end
`endif

  mw_pipe_reg u_mw_pipe_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .bubble (w_bubble),
    .d      (w_d),
    .q      (w_q)
  );

  assign RegWriteW   = w_q.m.reg_write;
  assign ResultSrcW  = w_q.m.result_src;
  assign RD_W        = w_q.m.rd;
  assign PCPlus4W    = w_q.m.pc_plus4;
  assign ALU_ResultW = w_q.m.alu_result;
  assign ReadDataW   = w_q.read_data;
  assign ResultW     = ResultSrcW ? ReadDataW : ALU_ResultW;

endmodule
